vga_vram_scanout: RTL and testbench

VGA_VRAM_SCANOUT -- requirements
Module: vga_vram_scanout

---
 rtl/vga_vram_scanout_if.sv | 19 +
 rtl/vga_vram_scanout.sv | 117 +++++++++++
 tb/tb_vga_vram_scanout.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/vga_vram_scanout_if.sv
// VRAM read port of the VGA scanout: registered address/enable out, 3-bit RGB pixel back.
// The pixel for an address is expected on iVramData one advancing cycle after it is presented.
interface vga_vram_scanout_if;
   logic [15:0] oVramAddress;
   logic        oVramReadEnable;
   logic [2:0]  iVramData;

   modport master (
      output oVramAddress,
      output oVramReadEnable,
      input  iVramData
   );

   modport slave (
      input  oVramAddress,
      input  oVramReadEnable,
      output iVramData
   );
endinterface

// File: rtl/vga_vram_scanout.sv
// VGA timing generator with a 256x256 VRAM window: counters -> address register -> output register,
// so every pin lags the counters by two pixel-enabled cycles and stays mutually aligned.
module vga_vram_scanout #(
   parameter int H_VISIBLE = 640,
   parameter int H_FRONT   = 16,
   parameter int H_SYNC    = 96,
   parameter int H_BACK    = 48,
   parameter int V_VISIBLE = 480,
   parameter int V_FRONT   = 10,
   parameter int V_SYNC    = 2,
   parameter int V_BACK    = 33,
   parameter int WIN_X0    = 192,
   parameter int WIN_Y0    = 112
) (
   input  logic                  Clock,
   input  logic                  Reset,
   input  logic                  iPixelEnable,
   vga_vram_scanout_if.master    vram,
   output logic                  oRed,
   output logic                  oGreen,
   output logic                  oBlue,
   output logic                  oHSync,
   output logic                  oVSync,
   output logic                  oFrameStart
);

   localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
   localparam int HW      = $clog2(H_TOTAL);
   localparam int VW      = $clog2(V_TOTAL);

   localparam logic [HW-1:0] H_MAX  = HW'(H_TOTAL - 1);
   localparam logic [HW-1:0] H_ONE  = HW'(1);
   localparam logic [HW-1:0] H_VIS  = HW'(H_VISIBLE);
   localparam logic [HW-1:0] X_LO   = HW'(WIN_X0);
   localparam logic [HW-1:0] X_HI   = HW'(WIN_X0 + 255);
   localparam logic [HW-1:0] HS_LO  = HW'(H_VISIBLE + H_FRONT);
   localparam logic [HW-1:0] HS_HI  = HW'(H_VISIBLE + H_FRONT + H_SYNC - 1);

   localparam logic [VW-1:0] V_MAX  = VW'(V_TOTAL - 1);
   localparam logic [VW-1:0] V_ONE  = VW'(1);
   localparam logic [VW-1:0] V_VIS  = VW'(V_VISIBLE);
   localparam logic [VW-1:0] Y_LO   = VW'(WIN_Y0);
   localparam logic [VW-1:0] Y_HI   = VW'(WIN_Y0 + 255);
   localparam logic [VW-1:0] VS_LO  = VW'(V_VISIBLE + V_FRONT);
   localparam logic [VW-1:0] VS_HI  = VW'(V_VISIBLE + V_FRONT + V_SYNC - 1);

   logic [HW-1:0] h_q, h_d;
   logic [VW-1:0] v_q, v_d;
   logic [15:0]   addr_q, addr_d;
   logic          ren_q;
   logic          vis1_q, hs1_q, vs1_q, fs1_q;
   logic [2:0]    rgb_q;
   logic          hs_q, vs_q, fs_q;

   logic in_win, vis, hs_n, vs_n, fs;

   always_comb begin
      h_d = h_q;
      v_d = v_q;
      if (h_q == H_MAX) begin
         h_d = '0;
         v_d = (v_q == V_MAX) ? '0 : v_q + V_ONE;
      end else begin
         h_d = h_q + H_ONE;
      end

      in_win = (h_q >= X_LO) && (h_q <= X_HI) && (v_q >= Y_LO) && (v_q <= Y_HI);
      vis    = (h_q < H_VIS) && (v_q < V_VIS);
      hs_n   = !((h_q >= HS_LO) && (h_q <= HS_HI));
      vs_n   = !((v_q >= VS_LO) && (v_q <= VS_HI));
      fs     = (h_q == '0) && (v_q == '0);
      // Window offsets truncate to 8 bits per axis, matching the CPU write layout {row, col}.
      addr_d = in_win ? {8'(v_q - Y_LO), 8'(h_q - X_LO)} : 16'h0000;
   end

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         h_q    <= '0;
         v_q    <= '0;
         addr_q <= 16'h0000;
         ren_q  <= 1'b0;
         vis1_q <= 1'b0;
         hs1_q  <= 1'b1;
         vs1_q  <= 1'b1;
         fs1_q  <= 1'b0;
         rgb_q  <= 3'b000;
         hs_q   <= 1'b1;
         vs_q   <= 1'b1;
         fs_q   <= 1'b0;
      end else if (iPixelEnable) begin
         h_q    <= h_d;
         v_q    <= v_d;
         addr_q <= addr_d;
         ren_q  <= in_win;
         vis1_q <= vis;
         hs1_q  <= hs_n;
         vs1_q  <= vs_n;
         fs1_q  <= fs;
         // iVramData now belongs to addr_q; ren_q doubles as the delayed window flag.
         rgb_q  <= (ren_q && vis1_q) ? vram.iVramData : 3'b000;
         hs_q   <= hs1_q;
         vs_q   <= vs1_q;
         fs_q   <= fs1_q;
      end
   end

   assign vram.oVramAddress    = addr_q;
   assign vram.oVramReadEnable = ren_q;
   assign oRed        = rgb_q[2];
   assign oGreen      = rgb_q[1];
   assign oBlue       = rgb_q[0];
   assign oHSync      = hs_q;
   assign oVSync      = vs_q;
   assign oFrameStart = fs_q;

endmodule

// File: tb/tb_vga_vram_scanout.sv
// Bench for vga_vram_scanout on a shrunken raster (268 x 262) that still holds a full 256x256 window.
// Scoreboard model predicts address and pins per advancing cycle; a table probes corner pixels.
module tb_vga_vram_scanout;
   localparam int HV = 260, HF = 2, HSY = 4, HB = 2;
   localparam int VV = 258, VF = 1, VSY = 2, VB = 1;
   localparam int WX0 = 4, WY0 = 2;
   localparam int HT = HV + HF + HSY + HB;
   localparam int VT = VV + VF + VSY + VB;

   logic clk = 1'b0;
   logic rst_n;
   logic pe;
   logic force_hi;
   logic red, green, blue, hsync, vsync, fstart;

   always #5 clk = ~clk;

   vga_vram_scanout_if vif ();
   // VRAM model: data = addr[2:0], presented during the cycle after the address register loads.
   assign vif.iVramData = force_hi ? 3'b111 : vif.oVramAddress[2:0];

   vga_vram_scanout #(
      .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HSY), .H_BACK(HB),
      .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VSY), .V_BACK(VB),
      .WIN_X0(WX0), .WIN_Y0(WY0)
   ) dut (
      .Clock(clk), .Reset(rst_n), .iPixelEnable(pe), .vram(vif),
      .oRed(red), .oGreen(green), .oBlue(blue),
      .oHSync(hsync), .oVSync(vsync), .oFrameStart(fstart)
   );

   typedef struct packed {
      logic        win;
      logic [15:0] addr;
      logic [2:0]  rgb;
      logic        hs;
      logic        vs;
      logic        fs;
   } rec_t;

   typedef struct {
      int h; int v; bit frc;
      int addr; int ren; int rgb; int hs; int vs;
   } vec_t;

   int   n_cmp = 0, n_fail = 0;
   rec_t exp_q[$];
   rec_t pin_exp;
   bit   have_pin;
   int   mh, mv, last_h, last_v;
   int   pe_div, phase, cyc, adv_cnt;
   int   hs_fall, hs_period, hs_low, vs_fall, vs_low, fs_rise, fs_period, fs_width;
   logic prev_hs, prev_vs, prev_fs;
   vec_t tbl[11];

   task automatic chk(input string name, input int act, input int expv);
      n_cmp++;
      if (act != expv) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h required 0x%0h (cycle %0d)", name, act, expv, cyc);
      end
   endtask

   function automatic rec_t model(input int h, input int v);
      rec_t r;
      r.win  = (h >= WX0) && (h <= WX0 + 255) && (v >= WY0) && (v <= WY0 + 255);
      r.addr = r.win ? 16'((((v - WY0) & 255) << 8) | ((h - WX0) & 255)) : 16'h0000;
      r.rgb  = 3'b000;
      r.hs   = !((h >= HV + HF) && (h < HV + HF + HSY));
      r.vs   = !((v >= VV + VF) && (v < VV + VF + VSY));
      r.fs   = (h == 0) && (v == 0);
      return r;
   endfunction

   task automatic sb_reset();
      exp_q.delete();
      have_pin = 1'b0;
      mh = 0; mv = 0; last_h = -1; last_v = -1;
   endtask

   task automatic meas_reset();
      hs_fall = -1; hs_period = -1; hs_low = -1;
      vs_fall = -1; vs_low = -1;
      fs_rise = -1; fs_period = -1; fs_width = -1;
      prev_hs = 1'b1; prev_vs = 1'b1; prev_fs = 1'b0;
   endtask

   task automatic sb_advance();
      if (exp_q.size() > 0) begin
         pin_exp = exp_q.pop_front();
         pin_exp.rgb = pin_exp.win ? (force_hi ? 3'b111 : pin_exp.addr[2:0]) : 3'b000;
         have_pin = 1'b1;
      end
      exp_q.push_back(model(mh, mv));
      last_h = mh; last_v = mv;
      if (mh == HT - 1) begin
         mh = 0;
         mv = (mv == VT - 1) ? 0 : mv + 1;
      end else begin
         mh = mh + 1;
      end
   endtask

   task automatic sb_check();
      if (exp_q.size() > 0)
         chk("sb_addr", {vif.oVramReadEnable, vif.oVramAddress}, {exp_q[0].win, exp_q[0].addr});
      else
         chk("rst_addr", {vif.oVramReadEnable, vif.oVramAddress}, 0);
      if (have_pin)
         chk("sb_pins", {red, green, blue, hsync, vsync, fstart},
             {pin_exp.rgb, pin_exp.hs, pin_exp.vs, pin_exp.fs});
      else
         chk("rst_pins", {red, green, blue, hsync, vsync, fstart}, 6'b000110);
   endtask

   task automatic meas();
      cyc++;
      if (prev_hs && !hsync) begin
         if (hs_fall >= 0) hs_period = cyc - hs_fall;
         hs_fall = cyc;
      end
      if (!prev_hs && hsync && hs_fall >= 0) hs_low = cyc - hs_fall;
      if (prev_vs && !vsync) vs_fall = cyc;
      if (!prev_vs && vsync && vs_fall >= 0) vs_low = cyc - vs_fall;
      if (!prev_fs && fstart) begin
         if (fs_rise >= 0) fs_period = cyc - fs_rise;
         fs_rise = cyc;
      end
      if (prev_fs && !fstart && fs_rise >= 0) fs_width = cyc - fs_rise;
      prev_hs = hsync; prev_vs = vsync; prev_fs = fstart;
   endtask

   // One clock: drive pe at the falling edge, update the model at the rising edge, check after.
   task automatic tick();
      pe = (phase == 0);
      phase = (phase + 1) % pe_div;
      @(posedge clk);
      if (pe && rst_n) begin
         adv_cnt++;
         sb_advance();
      end
      @(negedge clk);
      sb_check();
      meas();
   endtask

   task automatic wait_point(input int h, input int v);
      int n = 0;
      while (!(last_h == h && last_v == v) && n < 80000) begin
         tick();
         n++;
      end
      if (!(last_h == h && last_v == v)) begin
         n_cmp++;
         n_fail++;
         $display("FAIL wait_point: got (%0d,%0d) required (%0d,%0d)", last_h, last_v, h, v);
      end
   endtask

   initial begin
      //         h    v    frc  addr     ren rgb hs vs
      tbl[0]  = '{4,   2,   0, 16'h0000, 1, 0, 1, 1};
      tbl[1]  = '{11,  2,   0, 16'h0007, 1, 7, 1, 1};
      tbl[2]  = '{1,   5,   0, 16'h0000, 0, 0, 1, 1};
      tbl[3]  = '{263, 5,   1, 16'h0000, 0, 0, 0, 1};
      tbl[4]  = '{266, 5,   1, 16'h0000, 0, 0, 1, 1};
      tbl[5]  = '{105, 50,  0, 16'h3065, 1, 5, 1, 1};
      tbl[6]  = '{259, 257, 0, 16'hFFFF, 1, 7, 1, 1};
      tbl[7]  = '{260, 257, 0, 16'h0000, 0, 0, 1, 1};
      tbl[8]  = '{4,   258, 0, 16'h0000, 0, 0, 1, 1};
      tbl[9]  = '{100, 259, 0, 16'h0000, 0, 0, 1, 0};
      tbl[10] = '{100, 261, 0, 16'h0000, 0, 0, 1, 1};

      rst_n = 1'b0; pe = 1'b0; force_hi = 1'b0;
      pe_div = 1; phase = 0; cyc = 0; adv_cnt = 0;
      sb_reset();
      meas_reset();
      repeat (2) @(negedge clk);

      // Reset held with pixel enable active: nothing may move.
      repeat (4) tick();

      rst_n = 1'b1;
      adv_cnt = 0;
      for (int n = 0; n < 40 && !fstart; n++) tick();
      chk("first_fs_latency", adv_cnt, 2);

      for (int i = 0; i < 11; i++) begin
         force_hi = tbl[i].frc;
         wait_point(tbl[i].h, tbl[i].v);
         chk($sformatf("tbl%0d_addr", i), {vif.oVramReadEnable, vif.oVramAddress},
             {tbl[i].ren[0], tbl[i].addr[15:0]});
         tick();
         chk($sformatf("tbl%0d_pins", i), {red, green, blue, hsync, vsync},
             {tbl[i].rgb[2:0], tbl[i].hs[0], tbl[i].vs[0]});
      end
      force_hi = 1'b0;

      wait_point(0, 0);
      repeat (3) tick();
      chk("hs_period", hs_period, HT);
      chk("hs_low", hs_low, HSY);
      chk("vs_low", vs_low, VSY * HT);
      chk("fs_period", fs_period, HT * VT);
      chk("fs_width", fs_width, 1);

      // Asynchronous reset in the middle of a window line, away from any clock edge.
      wait_point(153, 3);
      #2 rst_n = 1'b0;
      #1 chk("async_rst", {vif.oVramReadEnable, vif.oVramAddress, red, green, blue, hsync, vsync, fstart},
             {1'b0, 16'h0000, 6'b000110});
      sb_reset();
      meas_reset();
      @(negedge clk);
      repeat (3) tick();

      pe_div = 4; phase = 2;
      rst_n = 1'b1;
      adv_cnt = 0;
      for (int n = 0; n < 40 && !fstart; n++) tick();
      chk("fs_latency_div4", adv_cnt, 2);

      repeat (HT * 4 * 3 + 50) tick();
      chk("hs_period_div4", hs_period, HT * 4);
      chk("hs_low_div4", hs_low, HSY * 4);
      chk("fs_width_div4", fs_width, 4);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
